// File: rtl/lfsr_pkg.sv
// Shared LFSR constants and helpers for the random-number bank.
// Taps are right-shift Galois masks; bit 0 of the state is the feedback bit.
package lfsr_pkg;

  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;
  localparam logic [63:0] LFSR_TAPS_64 = 64'hD800000000000000;

  function automatic logic [63:0] lfsr_default_taps(input int unsigned w);
    case (w)
      16:      return 64'(LFSR_TAPS_16);
      64:      return LFSR_TAPS_64;
      default: return 64'(LFSR_TAPS_32);
    endcase
  endfunction

  // Operands narrower than 64 bits must be zero-extended by the caller.
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps);
    return state[0] ? ((state >> 1) ^ taps) : (state >> 1);
  endfunction

endpackage

// File: rtl/lfsr_chan.sv
// One LFSR channel: state register, registered output word and range scaler.
// The output register follows a valid/ready handshake; seed loads take priority.
module lfsr_chan
  import lfsr_pkg::*;
#(
  parameter int            W     = 32,
  parameter logic [W-1:0]  TAPS  = W'(lfsr_default_taps(W)),
  parameter int            IDX_W = 16,
  parameter logic [W-1:0]  SEED  = W'(1)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             seed_we_i,
  input  logic [W-1:0]     seed_data_i,
  input  logic [IDX_W-1:0] range_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [W-1:0]     rand_o,
  output logic [IDX_W-1:0] idx_o
);

  localparam logic [W-1:0] RESET_STATE = (SEED == '0) ? W'(1) : SEED;

  logic [W-1:0]       state_q, state_d;
  logic [W-1:0]       rand_q, rand_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic               fill;
  logic [W+IDX_W-1:0] product;

  assign fill    = enable_i & ~seed_we_i & (~valid_q | ready_i);
  // Upper IDX_W bits of state*range map the word uniformly into [0, range).
  assign product = (W+IDX_W)'(state_q) * (W+IDX_W)'(range_i);

  always_comb begin
    state_d = state_q;
    rand_d  = rand_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (seed_we_i) begin
      state_d = (seed_data_i == '0) ? W'(1) : seed_data_i;
      valid_d = 1'b0;
    end else if (fill) begin
      rand_d  = state_q;
      idx_d   = IDX_W'(product >> W);
      state_d = W'(lfsr_next(64'(state_q), 64'(TAPS)));
      valid_d = 1'b1;
    end else if (ready_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= RESET_STATE;
      rand_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rand_q  <= rand_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign rand_o  = rand_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/lfsr_bank.sv
// N-channel Galois LFSR bank: one independent lfsr_chan per walker lane.
// Channel i resets to SEED_BASE+i, with a zero seed forced to 1.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int           N_CH      = 4,
  parameter int           W         = 32,
  parameter logic [W-1:0] TAPS      = W'(lfsr_default_taps(W)),
  parameter int           IDX_W     = 16,
  parameter logic [W-1:0] SEED_BASE = W'(1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       seed_we,
  input  logic [W-1:0]          seed_data,
  input  logic [N_CH*IDX_W-1:0] range_in,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [N_CH*W-1:0]     out_rand,
  output logic [N_CH*IDX_W-1:0] out_idx
);

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
    localparam logic [W-1:0] SEED_I = SEED_BASE + W'(gi);

    lfsr_chan #(
      .W     (W),
      .TAPS  (TAPS),
      .IDX_W (IDX_W),
      .SEED  ((SEED_I == '0) ? W'(1) : SEED_I)
    ) u_chan (
      .clk         (clk),
      .reset_i     (reset),
      .enable_i    (enable),
      .seed_we_i   (seed_we[gi]),
      .seed_data_i (seed_data),
      .range_i     (range_in[gi*IDX_W +: IDX_W]),
      .ready_i     (out_ready[gi]),
      .valid_o     (out_valid[gi]),
      .rand_o      (out_rand[gi*W +: W]),
      .idx_o       (out_idx[gi*IDX_W +: IDX_W])
    );
  end

endmodule
